// File: rtl/i2c_pkg.sv
// Shared types for the I2C byte master: command codes, FSM states,
// and the transfer direction carried in the address byte.
package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_START     = 3'd0,
        CMD_STOP      = 3'd1,
        CMD_WRITE     = 3'd2,
        CMD_READ_ACK  = 3'd3,
        CMD_READ_NACK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        START_A,
        START_B,
        START_C,
        START_D,
        BIT_Q0,
        BIT_Q1,
        BIT_Q2,
        BIT_Q3,
        STOP_A,
        STOP_B,
        STOP_C,
        RESP
    } i2c_state_t;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    // Reserved codes, or anything but START while the bus is free
    function automatic logic cmd_illegal(logic [2:0] op, logic owned);
        return (op > 3'(CMD_READ_NACK)) ||
               ((op != 3'(CMD_START)) && !owned);
    endfunction

endpackage

// File: rtl/i2c_byte_master_if.sv
// Command/response handshake between a controller and the byte engine.
// The engine side is the slave modport.
interface i2c_byte_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_nack;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err
    );
endinterface

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timebase for SCL; holds at zero while a released
// SCL is still being held low by a stretching slave.
module i2c_quarter_timer #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic s_rst,
    input  logic run,
    input  logic hold,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (s_rst || !run || hold) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && !hold && (cnt == LAST);

endmodule

// File: rtl/i2c_byte_master.sv
// Single-master I2C byte engine: START/STOP/WRITE/READ commands on an
// open-drain bus with quarter-period timing and clock stretching.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV        = 25,
    parameter int I2C_DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             s_rst,
    i2c_byte_master_if.slave host,
    output logic             bus_owned,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_low,
    output logic             sda_low
);
    localparam int W  = I2C_DATA_WIDTH;
    localparam int BW = $clog2(W + 1);

    i2c_state_t    state, nxt;
    logic [2:0]    op_q;
    logic [W-1:0]  sh;
    logic [BW-1:0] bit_cnt;
    logic          owned;
    logic          tick, run, hold;
    logic          accept, last_bit, is_rd, slot_sda;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_nack, rsp_err;

    assign accept   = host.cmd_valid && host.cmd_ready;
    assign last_bit = (bit_cnt == BW'(W));
    assign is_rd    = (op_q == 3'(CMD_READ_ACK)) ||
                      (op_q == 3'(CMD_READ_NACK));
    // Ninth slot: release for a write's ACK, or drive our own ACK on reads
    assign slot_sda = last_bit ? (op_q == 3'(CMD_READ_ACK))
                               : (!is_rd && !sh[W-1]);
    assign run      = (state != IDLE) && (state != RESP);
    assign hold     = !scl_low && !scl_i;

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .s_rst (s_rst),
        .run   (run),
        .hold  (hold),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (s_rst) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, RESP: begin
                nxt = IDLE;
                if (accept) begin
                    if (cmd_illegal(host.cmd_op, owned))
                        nxt = RESP;
                    else if (host.cmd_op == 3'(CMD_START))
                        nxt = START_A;
                    else if (host.cmd_op == 3'(CMD_STOP))
                        nxt = STOP_A;
                    else
                        nxt = BIT_Q0;
                end
            end
            START_A: if (tick) nxt = START_B;
            START_B: if (tick) nxt = START_C;
            START_C: if (tick) nxt = owned ? START_D : RESP;
            START_D: if (tick) nxt = RESP;
            BIT_Q0:  if (tick) nxt = BIT_Q1;
            BIT_Q1:  if (tick) nxt = BIT_Q2;
            BIT_Q2:  if (tick) nxt = BIT_Q3;
            BIT_Q3:  if (tick) nxt = last_bit ? RESP : BIT_Q0;
            STOP_A:  if (tick) nxt = STOP_B;
            STOP_B:  if (tick) nxt = STOP_C;
            STOP_C:  if (tick) nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        scl_low        = 1'b0;
        sda_low        = 1'b0;
        host.cmd_ready = 1'b0;
        host.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                scl_low        = owned;
                host.cmd_ready = 1'b1;
            end
            RESP: begin
                scl_low        = owned;
                host.cmd_ready = 1'b1;
                host.rsp_valid = 1'b1;
            end
            START_A: scl_low = owned;
            START_B: sda_low = !owned;
            START_C: begin
                scl_low = !owned;
                sda_low = 1'b1;
            end
            START_D: begin
                scl_low = 1'b1;
                sda_low = 1'b1;
            end
            BIT_Q0: begin
                scl_low = 1'b1;
                sda_low = slot_sda;
            end
            BIT_Q1, BIT_Q2, BIT_Q3: sda_low = slot_sda;
            STOP_A: begin
                scl_low = 1'b1;
                sda_low = 1'b1;
            end
            STOP_B: sda_low = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            op_q      <= '0;
            sh        <= '0;
            bit_cnt   <= '0;
            owned     <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= host.cmd_op;
                sh      <= host.cmd_wdata;
                bit_cnt <= '0;
            end else if (state == BIT_Q3 && tick && !last_bit) begin
                sh      <= {sh[W-2:0], sda_i};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (nxt == RESP) begin
                rsp_err   <= (state == IDLE) || (state == RESP);
                rsp_rdata <= (state == BIT_Q3 && is_rd) ? sh : '0;
                rsp_nack  <= (state == BIT_Q3) &&
                             (op_q == 3'(CMD_WRITE)) && sda_i;
            end
            if (tick && (state == START_C || state == START_D))
                owned <= 1'b1;
            else if (tick && state == STOP_C)
                owned <= 1'b0;
        end
    end

    assign host.rsp_rdata = rsp_rdata;
    assign host.rsp_nack  = rsp_nack;
    assign host.rsp_err   = rsp_err;
    assign bus_owned      = owned;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: command vector table against a small
// synchronous slave responder at address 0x22, plus stretch/reset cases.
module tb_i2c_byte_master;
    import i2c_pkg::*;

    localparam int D    = 4;
    localparam int L_ST = 3 * D + 1;
    localparam int L_RS = 4 * D + 1;
    localparam int L_SP = 3 * D + 1;
    localparam int L_X  = 36 * D + 1;
    localparam int NV   = 21;

    logic clk = 1'b0;
    logic s_rst = 1'b1;
    logic bus_owned, scl_i, sda_i, scl_low, sda_low;

    always #5 clk = ~clk;

    i2c_byte_master_if #(.DATA_WIDTH(8)) host ();

    i2c_byte_master #(.CLK_DIV(D), .I2C_DATA_WIDTH(8)) dut (
        .clk       (clk),
        .s_rst     (s_rst),
        .host      (host),
        .bus_owned (bus_owned),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_low   (scl_low),
        .sda_low   (sda_low)
    );

    // Slave responder state
    logic       ps, pd, drive, active, is_read, mack;
    logic       rd_done = 1'b0, xfer_done = 1'b0;
    logic [7:0] sr, rd_sh;
    logic [7:0] rd_mem [2] = '{8'hA5, 8'h3C};
    int         bit_i, phase, idx, st_cnt;
    bit         stretch_en = 1'b0;
    bit         load;
    logic [7:0] wr_q [$];
    i2c_op_t    op_log [$];

    assign scl_i = !(scl_low || st_cnt != 0);
    assign sda_i = !(sda_low || drive);

    always @(negedge clk) begin
        if (s_rst) begin
            ps = 1'b1; pd = 1'b1; active = 1'b0; drive = 1'b0;
            bit_i = 0; phase = 0; st_cnt = 0; idx = 0;
        end else begin
            if (st_cnt != 0) st_cnt--;
            if (ps && scl_i && pd && !sda_i) begin
                active = 1'b1; phase = 0; bit_i = 0; drive = 1'b0;
            end else if (ps && scl_i && !pd && sda_i) begin
                if (rd_done) xfer_done = 1'b1;
                active = 1'b0; drive = 1'b0;
            end else if (active && !ps && scl_i) begin
                if (bit_i < 8) begin
                    sr = {sr[6:0], sda_i};
                    bit_i++;
                end else begin
                    mack  = !sda_i;
                    bit_i = 9;
                end
            end else if (active && ps && !scl_i) begin
                if (stretch_en && bit_i == 3) st_cnt = 500;
                if (bit_i == 8) begin
                    if (phase == 0) begin
                        if (sr[7:1] == 7'h22) begin
                            drive   = 1'b1;
                            is_read = sr[0];
                            op_log.push_back(sr[0] ? I2C_READ : I2C_WRITE);
                        end else begin
                            active = 1'b0; drive = 1'b0;
                        end
                    end else if (phase == 1) begin
                        drive = 1'b1;
                        wr_q.push_back(sr);
                    end else begin
                        drive = 1'b0;
                    end
                end else if (bit_i == 9) begin
                    bit_i = 0;
                    load  = 1'b0;
                    if (phase == 0) begin
                        phase = is_read ? 2 : 1;
                        idx   = 0;
                        load  = is_read;
                    end else if (phase == 2) begin
                        if (mack) begin
                            idx++;
                            load = 1'b1;
                        end else begin
                            rd_done = 1'b1;
                            active  = 1'b0;
                        end
                    end
                    if (load) begin
                        rd_sh = rd_mem[idx % 2];
                        drive = !rd_sh[7];
                    end else begin
                        drive = 1'b0;
                    end
                end else if (phase == 2 && bit_i >= 1 && bit_i <= 7) begin
                    drive = !rd_sh[7 - bit_i];
                end
            end
            ps = scl_i;
            pd = sda_i;
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] wd;
        int         lat;
        logic [7:0] rd;
        logic       nack;
        logic       err;
        logic       own;
    } vec_t;

    vec_t vecs [NV];
    int   passed = 0;
    int   total = 0;
    int   lat;
    logic r_scl, r_sda;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] wd,
                           output int l);
        bit got = 1'b0;
        l = 0;
        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_wdata = wd;
        @(posedge clk);
        #1 host.cmd_valid = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            l++;
            if (host.rsp_valid) begin
                got   = 1'b1;
                r_scl = scl_low;
                r_sda = sda_low;
            end
        end
        if (!got) begin
            total++;
            $display("FAIL rsp_timeout: op %0d got no rsp_valid, want one", op);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        host.cmd_valid = 1'b0;
        host.cmd_op    = '0;
        host.cmd_wdata = '0;

        vecs[0]  = '{3'd2, 8'h44, 1,    8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd7, 8'h00, 1,    8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 8'h00, 1,    8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'd0, 8'h00, L_ST, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'd2, 8'h44, L_X,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'd2, 8'h5A, L_X,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'd1, 8'h00, L_SP, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd0, 8'h00, L_ST, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'd2, 8'h45, L_X,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'd3, 8'h00, L_X,  8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'd4, 8'h00, L_X,  8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'd1, 8'h00, L_SP, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd0, 8'h00, L_ST, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'd2, 8'h60, L_X,  8'h00, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{3'd1, 8'h00, L_SP, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'd0, 8'h00, L_ST, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{3'd2, 8'h44, L_X,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{3'd0, 8'h00, L_RS, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{3'd2, 8'h45, L_X,  8'h00, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{3'd4, 8'h00, L_X,  8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{3'd1, 8'h00, L_SP, 8'h00, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_low", int'(scl_low), 0);
        chk("rst_sda_low", int'(sda_low), 0);
        chk("rst_cmd_ready", int'(host.cmd_ready), 1);
        chk("rst_rsp_valid", int'(host.rsp_valid), 0);
        chk("rst_rsp_rdata", int'(host.rsp_rdata), 0);
        chk("rst_rsp_nack", int'(host.rsp_nack), 0);
        chk("rst_rsp_err", int'(host.rsp_err), 0);
        chk("rst_bus_owned", int'(bus_owned), 0);
        @(negedge clk);
        s_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_cmd(vecs[i].op, vecs[i].wd, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_rdata", i), int'(host.rsp_rdata),
                int'(vecs[i].rd));
            chk($sformatf("v%0d_nack", i), int'(host.rsp_nack),
                int'(vecs[i].nack));
            chk($sformatf("v%0d_err", i), int'(host.rsp_err),
                int'(vecs[i].err));
            chk($sformatf("v%0d_owned", i), int'(bus_owned),
                int'(vecs[i].own));
        end

        chk("slave_wr_count", wr_q.size(), 1);
        chk("slave_wr_byte0", int'(wr_q[0]), 'h5A);
        chk("slave_op_count", op_log.size(), 4);
        chk("slave_op0", int'(op_log[0]), int'(I2C_WRITE));
        chk("slave_op1", int'(op_log[1]), int'(I2C_READ));
        chk("slave_xfer_done", int'(xfer_done), 1);

        // Illegal codes leave the lines as they were
        run_cmd(3'd7, 8'h00, lat);
        chk("ill_free_err", int'(host.rsp_err), 1);
        chk("ill_free_scl", int'(r_scl), 0);
        chk("ill_free_sda", int'(r_sda), 0);
        run_cmd(3'd0, 8'h00, lat);
        run_cmd(3'd5, 8'h00, lat);
        chk("ill_own_lat", lat, 1);
        chk("ill_own_err", int'(host.rsp_err), 1);
        chk("ill_own_scl", int'(r_scl), 1);
        chk("ill_own_owned", int'(bus_owned), 1);

        // Slave stretches SCL for 500 clocks at bit 3 of each byte
        stretch_en = 1'b1;
        run_cmd(3'd2, 8'h44, lat);
        chk_rng("str_addr_lat", lat, L_X + 500 - D - 2, L_X + 500 - D + 2);
        chk("str_addr_nack", int'(host.rsp_nack), 0);
        run_cmd(3'd2, 8'h77, lat);
        chk_rng("str_data_lat", lat, L_X + 500 - D - 2, L_X + 500 - D + 2);
        chk("str_data_nack", int'(host.rsp_nack), 0);
        stretch_en = 1'b0;
        run_cmd(3'd1, 8'h00, lat);
        chk("str_stop_owned", int'(bus_owned), 0);
        chk("str_wr_count", wr_q.size(), 2);
        chk("str_wr_byte", int'(wr_q[1]), 'h77);

        // Reset in the middle of a byte
        run_cmd(3'd0, 8'h00, lat);
        @(negedge clk);
        host.cmd_valid = 1'b1;
        host.cmd_op    = 3'd2;
        host.cmd_wdata = 8'h00;
        @(posedge clk);
        #1 host.cmd_valid = 1'b0;
        repeat (41) @(posedge clk);
        #1;
        chk("mid_scl_low_pre", int'(scl_low | sda_low), 1);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_scl_low", int'(scl_low), 0);
        chk("mid_rst_sda_low", int'(sda_low), 0);
        chk("mid_rst_cmd_ready", int'(host.cmd_ready), 1);
        chk("mid_rst_owned", int'(bus_owned), 0);
        @(negedge clk);
        s_rst = 1'b0;
        run_cmd(3'd0, 8'h00, lat);
        chk("post_rst_start_lat", lat, L_ST);
        run_cmd(3'd1, 8'h00, lat);
        chk("post_rst_stop_owned", int'(bus_owned), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Synthesizable single-master I2C byte engine. It is the initiator side of the bus whose responder is the slave BFM in the i2c verification package.
- Accepts one command at a time (START, STOP, WRITE byte, READ byte with ACK/NACK) from a controller FSM.
- Generates open-drain SCL/SDA with quarter-period timing and honours slave clock stretching.
- Returns one response per command: the received ACK for a write, the byte for a read, or an error.

Parameters:
- CLK_DIV, 25, system clocks per quarter SCL period (must be ≥2); SCL frequency = f_clk/(4*CLK_DIV).
- I2C_DATA_WIDTH, 8, bits per data transfer.

Ports:
- clk  in  1  system clock.
- s_rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_op  in  3  command code: 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NACK; others reserved.
- cmd_wdata  in  I2C_DATA_WIDTH  byte for WRITE.
- rsp_valid  out  1  one-cycle pulse per completed command.
- rsp_rdata  out  I2C_DATA_WIDTH  byte received by READ_*; 0 for other commands.
- rsp_nack  out  1  WRITE: slave NACKed (SDA high in the 9th bit).
- rsp_err  out  1  illegal command (reserved code, or STOP/WRITE/READ while bus not owned).
- bus_owned  out  1  high from START completion until STOP completion.
- scl_i  in  1  sampled SCL line.
- sda_i  in  1  sampled SDA line.
- scl_low  out  1  drive SCL low when 1 (open drain).
- sda_low  out  1  drive SDA low when 1 (open drain).

Behaviour:
- Reset:
  - scl_low=0, sda_low=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_nack=0, rsp_err=0, bus_owned=0, state IDLE, quarter counter 0.
  - Reset mid-transfer releases both lines in the next cycle. No STOP is generated.
- Handshake:
  - A command is accepted when cmd_valid&&cmd_ready. cmd_op and cmd_wdata are latched at acceptance.
  - cmd_ready drops the following cycle and rises again in the same cycle as rsp_valid.
  - The response fields hold their values until the next rsp_valid.
- Timing base:
  - Counter runs 0..CLK_DIV-1 and emits tick at CLK_DIV-1.
  - Each SCL-high quarter waits until scl_i==1 before the counter runs (stretch). The counter is held at 0 while scl_i==0.
- States: IDLE, START_A..START_D, BIT_Q0..BIT_Q3, STOP_A..STOP_C, RESP.
- START, bus not owned:
  - A: release SDA and SCL.
  - B: sda_low=1 while SCL high.
  - C: scl_low=1.
  - 3 ticks total, then bus_owned=1.
- START, bus owned (repeated start):
  - A: release SDA while SCL is low.
  - Then release SCL and wait for stretch.
  - D: sda_low=1, then scl_low=1.
  - 4 ticks total.
- WRITE: 9 bit slots, MSB first. In each slot:
  - Q0: SCL low, set sda_low=~bit.
  - Q1: release SCL (stretch-wait).
  - Q2: hold.
  - Q3: sample sda_i on the tick, then scl_low=1.
  - Slot 9 releases SDA; rsp_nack = sampled sda_i.
- READ: 8 slots with SDA released, sampled MSB first into rsp_rdata. Slot 9 drives sda_low=1 for READ_ACK and 0 for READ_NACK.
- STOP:
  - A: sda_low=1 with SCL low.
  - B: release SCL (stretch-wait).
  - C: release SDA.
  - bus_owned=0 after C.
- Illegal command: no bus activity, RESP next cycle with rsp_err=1.
- Latency: START 3 or 4 ticks, STOP 3 ticks, WRITE/READ 36 ticks (excluding stretch), +1 cycle to rsp_valid.
- Ownership: while bus_owned, SCL is left held low between commands.
- SDA changes only while SCL is low, except the START/STOP edges.

Decomposition:
- i2c_pkg holds:
  - typedef enum i2c_cmd_t {CMD_START, CMD_STOP, CMD_WRITE, CMD_READ_ACK, CMD_READ_NACK}.
  - The master state enum.
  - The existing i2c_op_t, used by the bench.
- One sub-module, i2c_quarter_timer (counter, tick, stretch hold), is natural. The bit/byte FSM stays in the top.

Test Plan:
- START, WRITE 0x44, WRITE 0x5A, STOP to the BFM at address 0x22 → BFM sees op=WRITE, data={0x5A}; both responses have rsp_nack=0; bus_owned ends 0.
- START, WRITE 0x45, READ_ACK, READ_NACK, STOP with BFM read data {0xA5,0x3C} → rsp_rdata 0xA5 then 0x3C; BFM transfer_complete=1.
- WRITE to address 0x30 (no responder, SDA pulled up) → rsp_nack=1; a following STOP is legal and completes.
- START, WRITE 0x44, START, WRITE 0x45 (repeated start) → START_A..D sequence with no STOP between; second write is accepted.
- BFM holds SCL low 500 clocks during Q1 of bit 3 → bit timing extends by 500 cycles; data is still correct.
- WRITE while bus not owned, and cmd_op=7 → rsp_err=1 one cycle after acceptance, lines untouched. s_rst asserted mid-byte → scl_low=sda_low=0 in the next cycle, cmd_ready=1.
